pa_falu_iwb_sched: RTL and testbench

Integer-writeback scheduler for the FALU. It arbitrates integer-destination results from the FSPU (fmv.x.w, fclass) and the FCVT/FCMP unit (fcvt.w[u].s, feq/flt/fle) onto the single RTU integer write port. A small FIFO absorbs RTU backpressure, so the EX1 producers see a simple request/grant handshake. It sits between the FALU EX1 sub-units and the RTU.

---
 rtl/pa_falu_iwb_sched.sv | 107 ++++++++++
 tb/tb_pa_falu_iwb_sched.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pa_falu_iwb_sched.sv
// Integer-writeback scheduler: round-robin arbitration of FSPU and FCVT/FCMP
// integer results into a small FIFO that drains onto the RTU write port.
module pa_falu_iwb_sched #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        cpuclk,
  input  logic        cpurst,
  input  logic        fspu_iwb_req,
  input  logic [31:0] fspu_iwb_data,
  input  logic [4:0]  fspu_iwb_dst,
  input  logic        fcvt_iwb_req,
  input  logic [31:0] fcvt_iwb_data,
  input  logic [4:0]  fcvt_iwb_dst,
  input  logic [4:0]  fcvt_iwb_fflags,
  input  logic        iwb_sched_flush,
  output logic        iwb_sched_fspu_grnt,
  output logic        iwb_sched_fcvt_grnt,
  input  logic        rtu_iwb_rdy,
  output logic        iwb_sched_rtu_vld,
  output logic [31:0] iwb_sched_rtu_data,
  output logic [4:0]  iwb_sched_rtu_dst,
  output logic [4:0]  iwb_sched_rtu_fflags,
  output logic        iwb_sched_empty,
  output logic        iwb_sched_full
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 42;

  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          r_rr;

  logic          w_deq;
  logic          w_space;
  logic          w_open;
  logic          w_fspu_grnt;
  logic          w_fcvt_grnt;
  logic          w_enq;
  logic          w_contend;
  logic [EW-1:0] w_wdata;
  logic [EW-1:0] w_head;

  assign w_deq   = iwb_sched_rtu_vld & rtu_iwb_rdy;
  // A full FIFO still has room when the head leaves in the same cycle.
  assign w_space = (r_cnt < CW'(FIFO_DEPTH)) | w_deq;
  assign w_open  = w_space & ~iwb_sched_flush;

  assign w_fspu_grnt = w_open & fspu_iwb_req & (~fcvt_iwb_req | ~r_rr);
  assign w_fcvt_grnt = w_open & fcvt_iwb_req & (~fspu_iwb_req | r_rr);
  assign w_enq       = w_fspu_grnt | w_fcvt_grnt;
  assign w_contend   = w_open & fspu_iwb_req & fcvt_iwb_req;

  assign w_wdata = w_fspu_grnt ? {fspu_iwb_data, fspu_iwb_dst, 5'b0}
                               : {fcvt_iwb_data, fcvt_iwb_dst, fcvt_iwb_fflags};

  assign iwb_sched_fspu_grnt = w_fspu_grnt;
  assign iwb_sched_fcvt_grnt = w_fcvt_grnt;

  always_ff @(posedge cpuclk) begin
    if (w_enq) begin
      r_mem[r_wptr] <= w_wdata;
    end
  end

  always_ff @(posedge cpuclk) begin
    if (cpurst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_rr   <= 1'b0;
    end else if (iwb_sched_flush) begin
      // A head dequeued during flush is already the RTU's to squash.
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_enq) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_deq) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_enq && !w_deq) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (!w_enq && w_deq) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_contend) begin
        r_rr <= ~r_rr;
      end
    end
  end

  assign w_head = r_mem[r_rptr];

  assign iwb_sched_rtu_vld    = (r_cnt != '0);
  assign iwb_sched_rtu_data   = iwb_sched_rtu_vld ? w_head[41:10] : 32'b0;
  assign iwb_sched_rtu_dst    = iwb_sched_rtu_vld ? w_head[9:5]   : 5'b0;
  assign iwb_sched_rtu_fflags = iwb_sched_rtu_vld ? w_head[4:0]   : 5'b0;
  assign iwb_sched_empty      = (r_cnt == '0);
  assign iwb_sched_full       = (r_cnt == CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_pa_falu_iwb_sched.sv
// Directed bench for pa_falu_iwb_sched: per-cycle vector table plus a
// pointer-wrap drain sequence checked against the stimulus order.
module tb_pa_falu_iwb_sched;

  logic        cpuclk = 1'b0;
  logic        cpurst;
  logic        fspu_iwb_req;
  logic [31:0] fspu_iwb_data;
  logic [4:0]  fspu_iwb_dst;
  logic        fcvt_iwb_req;
  logic [31:0] fcvt_iwb_data;
  logic [4:0]  fcvt_iwb_dst;
  logic [4:0]  fcvt_iwb_fflags;
  logic        iwb_sched_flush;
  logic        iwb_sched_fspu_grnt;
  logic        iwb_sched_fcvt_grnt;
  logic        rtu_iwb_rdy;
  logic        iwb_sched_rtu_vld;
  logic [31:0] iwb_sched_rtu_data;
  logic [4:0]  iwb_sched_rtu_dst;
  logic [4:0]  iwb_sched_rtu_fflags;
  logic        iwb_sched_empty;
  logic        iwb_sched_full;

  int errors = 0;
  int checks = 0;

  always #5 cpuclk = ~cpuclk;

  pa_falu_iwb_sched #(.FIFO_DEPTH(2)) dut (
    .cpuclk               (cpuclk),
    .cpurst               (cpurst),
    .fspu_iwb_req         (fspu_iwb_req),
    .fspu_iwb_data        (fspu_iwb_data),
    .fspu_iwb_dst         (fspu_iwb_dst),
    .fcvt_iwb_req         (fcvt_iwb_req),
    .fcvt_iwb_data        (fcvt_iwb_data),
    .fcvt_iwb_dst         (fcvt_iwb_dst),
    .fcvt_iwb_fflags      (fcvt_iwb_fflags),
    .iwb_sched_flush      (iwb_sched_flush),
    .iwb_sched_fspu_grnt  (iwb_sched_fspu_grnt),
    .iwb_sched_fcvt_grnt  (iwb_sched_fcvt_grnt),
    .rtu_iwb_rdy          (rtu_iwb_rdy),
    .iwb_sched_rtu_vld    (iwb_sched_rtu_vld),
    .iwb_sched_rtu_data   (iwb_sched_rtu_data),
    .iwb_sched_rtu_dst    (iwb_sched_rtu_dst),
    .iwb_sched_rtu_fflags (iwb_sched_rtu_fflags),
    .iwb_sched_empty      (iwb_sched_empty),
    .iwb_sched_full       (iwb_sched_full)
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic        rdy;
    logic        sreq;
    logic [31:0] sdata;
    logic [4:0]  sdst;
    logic        creq;
    logic [31:0] cdata;
    logic [4:0]  cdst;
    logic [4:0]  cff;
    logic        e_sg;
    logic        e_cg;
    logic        e_vld;
    logic [31:0] e_data;
    logic [4:0]  e_dst;
    logic [4:0]  e_ff;
    logic        e_empty;
    logic        e_full;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(int rst, int flush, int rdy,
                             int sreq, int sdata, int sdst,
                             int creq, int cdata, int cdst, int cff,
                             int sg, int cg, int vld, int data, int dst, int ff,
                             int empty, int full);
    vec_t r;
    r.rst = 1'(rst);   r.flush = 1'(flush); r.rdy = 1'(rdy);
    r.sreq = 1'(sreq); r.sdata = 32'(sdata); r.sdst = 5'(sdst);
    r.creq = 1'(creq); r.cdata = 32'(cdata); r.cdst = 5'(cdst); r.cff = 5'(cff);
    r.e_sg = 1'(sg);   r.e_cg = 1'(cg);     r.e_vld = 1'(vld);
    r.e_data = 32'(data); r.e_dst = 5'(dst); r.e_ff = 5'(ff);
    r.e_empty = 1'(empty); r.e_full = 1'(full);
    return r;
  endfunction

  task automatic drive_idle();
    cpurst = 1'b0; iwb_sched_flush = 1'b0; rtu_iwb_rdy = 1'b0;
    fspu_iwb_req = 1'b0; fspu_iwb_data = '0; fspu_iwb_dst = '0;
    fcvt_iwb_req = 1'b0; fcvt_iwb_data = '0; fcvt_iwb_dst = '0; fcvt_iwb_fflags = '0;
  endtask

  initial begin
    logic [46:0] got;
    logic [46:0] exp;
    int p;
    int d;
    logic [31:0] x_data;
    logic [4:0]  x_dst;
    logic [4:0]  x_ff;

    // reset state, single FSPU
    vecs.push_back(v(0,0,0, 0,0,0,       0,0,0,0,        0,0, 0,0,0,0,         1,0));
    vecs.push_back(v(0,0,1, 1,'h200,5,   0,0,0,0,        1,0, 0,0,0,0,         1,0));
    vecs.push_back(v(0,0,1, 0,0,0,       0,0,0,0,        0,0, 1,'h200,5,0,     0,0));
    vecs.push_back(v(0,0,1, 0,0,0,       0,0,0,0,        0,0, 0,0,0,0,         1,0));
    // contended round robin, rdy=1
    vecs.push_back(v(0,0,1, 1,'h11,1,    1,'h22,2,1,     1,0, 0,0,0,0,         1,0));
    vecs.push_back(v(0,0,1, 1,'h11,1,    1,'h22,2,1,     0,1, 1,'h11,1,0,      0,0));
    vecs.push_back(v(0,0,1, 1,'h11,1,    1,'h22,2,1,     1,0, 1,'h22,2,1,      0,0));
    vecs.push_back(v(0,0,1, 0,0,0,       0,0,0,0,        0,0, 1,'h11,1,0,      0,0));
    vecs.push_back(v(0,0,1, 0,0,0,       0,0,0,0,        0,0, 0,0,0,0,         1,0));
    // fill with rdy=0, full, enqueue+dequeue while full
    vecs.push_back(v(0,0,0, 1,'h33,3,    0,0,0,0,        1,0, 0,0,0,0,         1,0));
    vecs.push_back(v(0,0,0, 0,0,0,       1,'h44,4,'h10,  0,1, 1,'h33,3,0,      0,0));
    vecs.push_back(v(0,0,0, 1,'h55,6,    0,0,0,0,        0,0, 1,'h33,3,0,      0,1));
    vecs.push_back(v(0,0,1, 1,'h55,6,    0,0,0,0,        1,0, 1,'h33,3,0,      0,1));
    vecs.push_back(v(0,0,0, 0,0,0,       0,0,0,0,        0,0, 1,'h44,4,'h10,   0,1));
    vecs.push_back(v(0,0,1, 0,0,0,       0,0,0,0,        0,0, 1,'h44,4,'h10,   0,1));
    vecs.push_back(v(0,0,1, 0,0,0,       0,0,0,0,        0,0, 1,'h55,6,0,      0,0));
    vecs.push_back(v(0,0,0, 0,0,0,       0,0,0,0,        0,0, 0,0,0,0,         1,0));
    // flush with count=2 and a held FSPU request
    vecs.push_back(v(0,0,0, 1,'h66,7,    0,0,0,0,        1,0, 0,0,0,0,         1,0));
    vecs.push_back(v(0,0,0, 0,0,0,       1,'h77,8,3,     0,1, 1,'h66,7,0,      0,0));
    vecs.push_back(v(0,1,0, 1,'h88,9,    0,0,0,0,        0,0, 1,'h66,7,0,      0,1));
    vecs.push_back(v(0,0,0, 1,'h88,9,    0,0,0,0,        1,0, 0,0,0,0,         1,0));
    vecs.push_back(v(0,0,1, 0,0,0,       0,0,0,0,        0,0, 1,'h88,9,0,      0,0));
    vecs.push_back(v(0,0,0, 0,0,0,       0,0,0,0,        0,0, 0,0,0,0,         1,0));
    // reset mid-operation (rr is 1 beforehand, must return to FSPU priority)
    vecs.push_back(v(0,0,0, 1,'h99,10,   0,0,0,0,        1,0, 0,0,0,0,         1,0));
    vecs.push_back(v(1,0,0, 0,0,0,       0,0,0,0,        0,0, 1,'h99,10,0,     0,0));
    vecs.push_back(v(0,0,0, 0,0,0,       0,0,0,0,        0,0, 0,0,0,0,         1,0));
    vecs.push_back(v(0,0,1, 1,'hAA,11,   1,'hBB,12,8,    1,0, 0,0,0,0,         1,0));
    vecs.push_back(v(0,0,1, 0,0,0,       1,'hBB,12,8,    0,1, 1,'hAA,11,0,     0,0));
    vecs.push_back(v(0,0,1, 0,0,0,       0,0,0,0,        0,0, 1,'hBB,12,8,     0,0));
    vecs.push_back(v(0,0,0, 0,0,0,       0,0,0,0,        0,0, 0,0,0,0,         1,0));

    drive_idle();
    cpurst = 1'b1;
    repeat (2) @(posedge cpuclk);

    foreach (vecs[i]) begin
      @(negedge cpuclk);
      cpurst = vecs[i].rst; iwb_sched_flush = vecs[i].flush; rtu_iwb_rdy = vecs[i].rdy;
      fspu_iwb_req = vecs[i].sreq; fspu_iwb_data = vecs[i].sdata; fspu_iwb_dst = vecs[i].sdst;
      fcvt_iwb_req = vecs[i].creq; fcvt_iwb_data = vecs[i].cdata;
      fcvt_iwb_dst = vecs[i].cdst; fcvt_iwb_fflags = vecs[i].cff;
      #1;
      got = {iwb_sched_fspu_grnt, iwb_sched_fcvt_grnt, iwb_sched_rtu_vld, iwb_sched_rtu_data,
             iwb_sched_rtu_dst, iwb_sched_rtu_fflags, iwb_sched_empty, iwb_sched_full};
      exp = {vecs[i].e_sg, vecs[i].e_cg, vecs[i].e_vld, vecs[i].e_data,
             vecs[i].e_dst, vecs[i].e_ff, vecs[i].e_empty, vecs[i].e_full};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL vec%0d: got sg=%0b cg=%0b vld=%0b data=%h dst=%0d ff=%h empty=%0b full=%0b, required sg=%0b cg=%0b vld=%0b data=%h dst=%0d ff=%h empty=%0b full=%0b",
                 i, got[46], got[45], got[44], got[43:12], got[11:7], got[6:2], got[1], got[0],
                 exp[46], exp[45], exp[44], exp[43:12], exp[11:7], exp[6:2], exp[1], exp[0]);
      end else begin
        $display("vec%0d: sg=%0b cg=%0b vld=%0b data=%h dst=%0d ff=%h empty=%0b full=%0b",
                 i, got[46], got[45], got[44], got[43:12], got[11:7], got[6:2], got[1], got[0]);
      end
    end

    // Wrap-around: 7 held FCVT results, rdy toggling; deliveries must follow issue order.
    p = 0;
    d = 0;
    for (int cyc = 0; cyc < 60 && d < 7; cyc++) begin
      @(negedge cpuclk);
      drive_idle();
      fcvt_iwb_req    = (p < 7);
      fcvt_iwb_data   = 32'h1000 + 32'(p);
      fcvt_iwb_dst    = 5'(p + 1);
      fcvt_iwb_fflags = 5'(1 << (p % 5));
      rtu_iwb_rdy     = ((cyc % 2) == 0);
      #1;
      if (iwb_sched_rtu_vld && rtu_iwb_rdy) begin
        x_data = 32'h1000 + 32'(d);
        x_dst  = 5'(d + 1);
        x_ff   = 5'(1 << (d % 5));
        checks++;
        if ({iwb_sched_rtu_data, iwb_sched_rtu_dst, iwb_sched_rtu_fflags} !== {x_data, x_dst, x_ff}) begin
          errors++;
          $display("FAIL wrap%0d: got data=%h dst=%0d ff=%h, required data=%h dst=%0d ff=%h",
                   d, iwb_sched_rtu_data, iwb_sched_rtu_dst, iwb_sched_rtu_fflags, x_data, x_dst, x_ff);
        end else begin
          $display("wrap%0d: data=%h dst=%0d ff=%h", d, iwb_sched_rtu_data, iwb_sched_rtu_dst, iwb_sched_rtu_fflags);
        end
        d++;
      end
      if (iwb_sched_fcvt_grnt) p++;
    end

    @(negedge cpuclk);
    drive_idle();
    #1;
    checks++;
    if (d != 7 || p != 7 || iwb_sched_empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_done: got delivered=%0d issued=%0d empty=%0b, required delivered=7 issued=7 empty=1",
               d, p, iwb_sched_empty);
    end else begin
      $display("wrap_done: delivered=%0d issued=%0d empty=%0b", d, p, iwb_sched_empty);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
